// File: rtl/countdown.sv
// W-bit down counter shared by timer clients.
// Priority: reset, clear, load, decrement.
module countdown #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (dec) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin arbiter: first set bit of req at or above ptr, wrapping.
// Returns a one-hot winner and a valid flag.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          valid
);

  // Rotating priority search; the first hit blocks every later one.
  always_comb begin : search
    logic [PW-1:0] idx_s;
    logic          hit_s;
    winner = {N{1'b0}};
    valid  = 1'b0;
    idx_s  = {PW{1'b0}};
    hit_s  = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx_s         = PW'((int'(ptr) + k) % N);
      hit_s         = !valid && req[idx_s];
      winner[idx_s] = winner[idx_s] | hit_s;
      valid         = valid | hit_s;
    end
  end

endmodule

// File: rtl/delay_arbiter.sv
// Shares one countdown timer among N requesters: round-robin grant, one-shot delay,
// one-cycle done pulse to the owner when its delay expires.
module delay_arbiter #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] delay,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] COUNT_ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_r, state_next_s;
  logic [N-1:0]  grant_r, grant_next_s;
  logic [PW-1:0] ptr_r, ptr_next_s;
  logic [PW-1:0] owner_r, owner_next_s;
  logic [N-1:0]  winner_s;
  logic          win_valid_s;
  logic [PW-1:0] win_idx_s;
  logic [W-1:0]  win_delay_s;
  logic [W-1:0]  count_s;
  logic [W-1:0]  load_value_s;
  logic          load_s, clear_s, dec_s;
  logic          owner_req_s;
  logic [PW-1:0] ptr_after_s;

  rr_pick #(.N(N), .PW(PW)) u_rr_pick (
    .req    (req),
    .ptr    (ptr_r),
    .winner (winner_s),
    .valid  (win_valid_s)
  );

  countdown #(.W(W)) u_countdown (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear_s),
    .load       (load_s),
    .dec        (dec_s),
    .load_value (load_value_s),
    .count      (count_s)
  );

  // One-hot winner to index, and that requester's delay clamped to at least 1.
  always_comb begin
    win_idx_s = {PW{1'b0}};
    for (int i = 0; i < N; i++) begin
      win_idx_s = win_idx_s | (winner_s[i] ? PW'(i) : {PW{1'b0}});
    end
    win_delay_s  = delay[win_idx_s*W +: W];
    load_value_s = (win_delay_s == {W{1'b0}}) ? COUNT_ONE : win_delay_s;
  end

  assign owner_req_s = |(req & grant_r);
  assign ptr_after_s = (owner_r == PW'(N-1)) ? {PW{1'b0}} : owner_r + {{(PW-1){1'b0}}, 1'b1};

  // Next-state and timer control; abort is checked before expiry so it wins.
  always_comb begin
    state_next_s = state_r;
    grant_next_s = grant_r;
    ptr_next_s   = ptr_r;
    owner_next_s = owner_r;
    load_s       = 1'b0;
    clear_s      = 1'b0;
    dec_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (win_valid_s) begin
          grant_next_s = winner_s;
          owner_next_s = win_idx_s;
          load_s       = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (!owner_req_s || (count_s == COUNT_ONE)) begin
          grant_next_s = {N{1'b0}};
          ptr_next_s   = ptr_after_s;
          clear_s      = 1'b1;
          state_next_s = IDLE;
        end else begin
          dec_s = 1'b1;
        end
      end
      default: begin
        grant_next_s = {N{1'b0}};
        clear_s      = 1'b1;
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM, grant, owner and pointer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      grant_r <= {N{1'b0}};
      ptr_r   <= {PW{1'b0}};
      owner_r <= {PW{1'b0}};
    end else begin
      state_r <= state_next_s;
      grant_r <= grant_next_s;
      ptr_r   <= ptr_next_s;
      owner_r <= owner_next_s;
    end
  end

  assign grant = grant_r;
  assign busy  = |grant_r;
  assign done  = ((state_r == RUN) && owner_req_s && (count_s == COUNT_ONE)) ? grant_r : {N{1'b0}};

endmodule

// File: tb/tb_delay_arbiter.sv
// Directed self-checking bench for delay_arbiter (W=8, N=4).
module tb_delay_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic           clock;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] delay;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;

  int checks = 0;
  int errors = 0;

  delay_arbiter #(.W(W), .N(N)) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .delay (delay),
    .grant (grant),
    .done  (done),
    .busy  (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [N-1:0] g, input logic [N-1:0] d);
    check({tag, "_grant"}, 32'(grant), 32'(g));
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_busy"}, 32'(busy), 32'(|g));
  endtask

  task automatic set_delay(input int i, input logic [W-1:0] v);
    delay[i*W +: W] = v;
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    delay = '0;
    step();
    step();
    check_out("reset", 4'b0000, 4'b0000);
    check("reset_ptr", 32'(dut.ptr_r), 32'd0);
    check("reset_count", 32'(dut.count_s), 32'd0);
    reset = 1'b0;

    // Single request, delay 5
    req = 4'b0001;
    set_delay(0, 8'd5);
    for (int i = 1; i <= 5; i++) begin
      step();
      check_out("single", 4'b0001, (i == 5) ? 4'b0001 : 4'b0000);
    end
    req = 4'b0000;
    step();
    check_out("single_end", 4'b0000, 4'b0000);
    check("single_ptr", 32'(dut.ptr_r), 32'd1);

    // Round-robin fairness from ptr 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_delay(i, 8'd2);
    for (int g = 0; g < 5; g++) begin
      logic [N-1:0] oh;
      oh = 4'b0001 << (g % N);
      step();
      check_out("rr_first", oh, 4'b0000);
      step();
      check_out("rr_second", oh, oh);
      if (g == 4) req = 4'b0000;
      step();
      check_out("rr_idle", 4'b0000, 4'b0000);
    end
    check("rr_ptr", 32'(dut.ptr_r), 32'd1);

    // Zero delay behaves as one
    req = 4'b0100;
    set_delay(2, 8'd0);
    step();
    check_out("zero", 4'b0100, 4'b0100);
    req = 4'b0000;
    step();
    check_out("zero_end", 4'b0000, 4'b0000);
    check("zero_ptr", 32'(dut.ptr_r), 32'd3);

    // Abort: requester 1 wins from ptr 3, drops after 3 cycles, pending 2 goes next
    req = 4'b0110;
    set_delay(1, 8'd10);
    set_delay(2, 8'd3);
    for (int i = 1; i <= 3; i++) begin
      step();
      check_out("abort_run", 4'b0010, 4'b0000);
    end
    req = 4'b0100;
    check("abort_nodone", 32'(done), 32'd0);
    step();
    check_out("abort_drop", 4'b0000, 4'b0000);
    check("abort_ptr", 32'(dut.ptr_r), 32'd2);
    step();
    check_out("abort_next", 4'b0100, 4'b0000);
    req = 4'b0000;
    step();
    check_out("abort_next_end", 4'b0000, 4'b0000);

    // Reset mid-run at count 4
    req = 4'b1000;
    set_delay(3, 8'd6);
    step();
    step();
    step();
    check("midrun_count", 32'(dut.count_s), 32'd4);
    check_out("midrun_run", 4'b1000, 4'b0000);
    reset = 1'b1;
    step();
    check_out("midrun_reset", 4'b0000, 4'b0000);
    check("midrun_ptr", 32'(dut.ptr_r), 32'd0);
    check("midrun_cnt0", 32'(dut.count_s), 32'd0);
    reset = 1'b0;
    step();
    check_out("midrun_regrant", 4'b1000, 4'b0000);
    req = 4'b0000;
    step();
    check_out("midrun_abort", 4'b0000, 4'b0000);
    check("midrun_wrap_ptr", 32'(dut.ptr_r), 32'd0);

    // Max delay on the last requester, pointer wraps to 0
    req = 4'b1000;
    set_delay(3, 8'd255);
    for (int i = 1; i <= 255; i++) begin
      step();
      check_out("max", 4'b1000, (i == 255) ? 4'b1000 : 4'b0000);
    end
    req = 4'b0000;
    step();
    check_out("max_end", 4'b0000, 4'b0000);
    check("max_ptr", 32'(dut.ptr_r), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
